// File: rtl/adsr_poly_if.sv
// Bundled control/status signals for the polyphonic ADSR envelope generator.
// The bench drives the master side; adsr_poly attaches to the slave side.
interface adsr_poly_if #(
  parameter int VOICES  = 4,
  parameter int BITSIZE = 16
);
  logic                      sample_tick;
  logic [VOICES-1:0]         gate;
  logic [15:0]               att;
  logic [15:0]               dec;
  logic [15:0]               rel;
  logic [15:0]               sus;
  logic [VOICES*BITSIZE-1:0] amplitude;
  logic [VOICES-1:0]         active;
  logic                      busy;
  logic                      done;

  modport master (
    output sample_tick, gate, att, dec, rel, sus,
    input  amplitude, active, busy, done
  );

  modport slave (
    input  sample_tick, gate, att, dec, rel, sus,
    output amplitude, active, busy, done
  );
endinterface

// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope generator: one shared datapath walks the voices
// one per cycle after each sample_tick, updating state and accumulator.
module adsr_poly #(
  parameter int VOICES   = 4,
  parameter int BITSIZE  = 16,
  parameter int ACC_BITS = 26
) (
  input logic        clk,
  input logic        rst,
  adsr_poly_if.slave bus
);
  localparam int IDXW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [2:0] {
    ST_OFF, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE
  } voice_state_e;

  typedef enum logic {
    PS_IDLE, PS_RUN
  } pass_state_e;

  pass_state_e               r_passState;
  pass_state_e               w_passNext;
  logic [IDXW-1:0]           r_idx;
  logic                      r_done;
  logic [VOICES-1:0]         r_gate;
  logic [15:0]               r_att;
  logic [15:0]               r_dec;
  logic [15:0]               r_sus;
  logic [15:0]               r_rel;
  voice_state_e              r_state [VOICES];
  logic [ACC_BITS-1:0]       r_acc [VOICES];
  logic [VOICES-1:0]         r_prevGate;
  logic [VOICES*BITSIZE-1:0] r_amp;
  logic [VOICES-1:0]         r_active;

  voice_state_e              w_curState;
  voice_state_e              w_nextState;
  logic [ACC_BITS-1:0]       w_curAcc;
  logic [ACC_BITS-1:0]       w_nextAcc;
  logic [ACC_BITS-1:0]       w_sLevel;
  logic [ACC_BITS-1:0]       w_relExt;
  logic [ACC_BITS:0]         w_attSum;
  logic [ACC_BITS:0]         w_decDiff;
  logic                      w_gateBit;
  logic                      w_rise;
  logic                      w_lastVoice;

  assign w_curState  = r_state[r_idx];
  assign w_curAcc    = r_acc[r_idx];
  assign w_gateBit   = r_gate[r_idx];
  assign w_rise      = w_gateBit & ~r_prevGate[r_idx];
  assign w_lastVoice = (r_idx == IDXW'(VOICES - 1));
  assign w_sLevel    = ACC_BITS'(r_sus) << (ACC_BITS - 16);
  assign w_relExt    = ACC_BITS'(r_rel);
  // One extra bit on the sum/difference so overflow and borrow are visible
  assign w_attSum    = {1'b0, w_curAcc} + (ACC_BITS + 1)'(r_att);
  assign w_decDiff   = {1'b0, w_curAcc} - (ACC_BITS + 1)'(r_dec);

  always_comb begin
    w_nextState = w_curState;
    w_nextAcc   = w_curAcc;
    if (!w_rise && !w_gateBit &&
        (w_curState == ST_ATTACK || w_curState == ST_DECAY || w_curState == ST_SUSTAIN)) begin
      w_nextState = ST_RELEASE;
    end else if (w_rise || w_curState == ST_ATTACK) begin
      if (r_att == 16'd0 || w_attSum >= {1'b0, {ACC_BITS{1'b1}}}) begin
        w_nextAcc   = {ACC_BITS{1'b1}};
        w_nextState = ST_DECAY;
      end else begin
        w_nextAcc   = w_attSum[ACC_BITS-1:0];
        w_nextState = ST_ATTACK;
      end
    end else begin
      case (w_curState)
        ST_DECAY: begin
          if (r_dec == 16'd0 || w_curAcc <= w_sLevel || w_decDiff[ACC_BITS] ||
              w_decDiff[ACC_BITS-1:0] <= w_sLevel) begin
            w_nextAcc   = w_sLevel;
            w_nextState = ST_SUSTAIN;
          end else begin
            w_nextAcc = w_decDiff[ACC_BITS-1:0];
          end
        end
        ST_SUSTAIN: w_nextAcc = w_sLevel;
        ST_RELEASE: begin
          if (r_rel == 16'd0 || w_curAcc <= w_relExt) begin
            w_nextAcc   = '0;
            w_nextState = ST_OFF;
          end else begin
            w_nextAcc = w_curAcc - w_relExt;
          end
        end
        default: begin
          w_nextAcc   = '0;
          w_nextState = ST_OFF;
        end
      endcase
    end
  end

  always_comb begin
    w_passNext = r_passState;
    case (r_passState)
      PS_IDLE: if (bus.sample_tick) w_passNext = PS_RUN;
      PS_RUN:  if (w_lastVoice) w_passNext = PS_IDLE;
      default: w_passNext = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_passState <= PS_IDLE;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_gate      <= '0;
      r_att       <= '0;
      r_dec       <= '0;
      r_sus       <= '0;
      r_rel       <= '0;
      r_prevGate  <= '0;
      r_amp       <= '0;
      r_active    <= '0;
      for (int v = 0; v < VOICES; v++) begin
        r_state[v] <= ST_OFF;
        r_acc[v]   <= '0;
      end
    end else begin
      r_passState <= w_passNext;
      r_done      <= 1'b0;
      if (r_passState == PS_IDLE) begin
        if (bus.sample_tick) begin
          r_gate <= bus.gate;
          r_att  <= bus.att;
          r_dec  <= bus.dec;
          r_sus  <= bus.sus;
          r_rel  <= bus.rel;
          r_idx  <= '0;
        end
      end else begin
        r_state[r_idx]                  <= w_nextState;
        r_acc[r_idx]                    <= w_nextAcc;
        r_prevGate[r_idx]               <= w_gateBit;
        r_amp[r_idx*BITSIZE +: BITSIZE] <= w_nextAcc[ACC_BITS-1 -: BITSIZE];
        r_active[r_idx]                 <= (w_nextState != ST_OFF);
        if (w_lastVoice) r_done <= 1'b1;
        else             r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign bus.amplitude = r_amp;
  assign bus.active    = r_active;
  assign bus.busy      = (r_passState == PS_RUN);
  assign bus.done      = r_done;
endmodule

// File: tb/tb_adsr_poly.sv
// Directed self-checking bench for adsr_poly (VOICES=4, BITSIZE=16, ACC_BITS=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adsr_poly;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  adsr_poly_if #(.VOICES(4), .BITSIZE(16)) bus ();

  adsr_poly #(.VOICES(4), .BITSIZE(16), .ACC_BITS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ampOf(input int v);
    return bus.amplitude[v*16 +: 16];
  endfunction

  // One sample tick, then wait (bounded) for the pass to finish
  task automatic applyTick();
    int n;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pass_timeout: done=%b want 1 within 20 cycles", bus.done);
    end
  endtask

  task automatic applyTicks(input int count);
    for (int i = 0; i < count; i++) applyTick();
  endtask

  task automatic setRates(input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] s, input logic [15:0] r);
    bus.att = a;
    bus.dec = d;
    bus.sus = s;
    bus.rel = r;
  endtask

  task automatic test_reset();
    bus.sample_tick = 1'b0;
    bus.gate        = 4'b0000;
    setRates(16'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.amplitude !== 64'h0) begin
      bad++; $display("[TB] FAIL reset_amp: got %h want 0", bus.amplitude);
    end
    total++;
    if (bus.active !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_flags: active=%b busy=%b done=%b want 0000 0 0",
                      bus.active, bus.busy, bus.done);
    end
    bus.sample_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.sample_tick = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_over_tick: busy=%b want 0", bus.busy);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_over_tick_later: busy=%b done=%b want 0 0",
                      bus.busy, bus.done);
    end
  endtask

  task automatic test_timing();
    logic expBusy [7];
    logic expDone [7];
    expBusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.sample_tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.sample_tick = (c == 2);
      total++;
      if (bus.busy !== expBusy[c] || bus.done !== expDone[c]) begin
        bad++; $display("[TB] FAIL timing_c%0d: busy=%b done=%b want %b %b",
                        c, bus.busy, bus.done, expBusy[c], expDone[c]);
      end
    end
    bus.sample_tick = 1'b0;
  endtask

  task automatic test_envelope();
    setRates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
    bus.gate = 4'b0001;
    applyTicks(63);
    total++;
    if (ampOf(0) !== 16'hFC00 || bus.active !== 4'b0001) begin
      bad++; $display("[TB] FAIL env_attack63: amp=%h active=%b want FC00 0001", ampOf(0), bus.active);
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL env_peak: got %h want FFFF", ampOf(0));
    end
    applyTicks(127);
    total++;
    if (ampOf(0) !== 16'h80FF) begin
      bad++; $display("[TB] FAIL env_decay127: got %h want 80FF", ampOf(0));
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'h8000) begin
      bad++; $display("[TB] FAIL env_sustain: got %h want 8000", ampOf(0));
    end
    applyTicks(5);
    total++;
    if (ampOf(0) !== 16'h8000 || bus.amplitude[63:16] !== 48'h0) begin
      bad++; $display("[TB] FAIL env_hold: amp=%h want 0000000000008000", bus.amplitude);
    end
    bus.gate = 4'b0000;
    applyTick();
    total++;
    if (ampOf(0) !== 16'h8000 || bus.active !== 4'b0001) begin
      bad++; $display("[TB] FAIL env_rel_entry: amp=%h active=%b want 8000 0001", ampOf(0), bus.active);
    end
    applyTicks(63);
    total++;
    if (ampOf(0) !== 16'h0200 || bus.active !== 4'b0001) begin
      bad++; $display("[TB] FAIL env_rel63: amp=%h active=%b want 0200 0001", ampOf(0), bus.active);
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'h0000 || bus.active !== 4'b0000) begin
      bad++; $display("[TB] FAIL env_off: amp=%h active=%b want 0000 0000", ampOf(0), bus.active);
    end
  endtask

  task automatic test_early_release();
    bus.gate = 4'b0001;
    applyTicks(10);
    total++;
    if (ampOf(0) !== 16'h2800) begin
      bad++; $display("[TB] FAIL early_attack10: got %h want 2800", ampOf(0));
    end
    bus.gate = 4'b0000;
    applyTick();
    total++;
    if (ampOf(0) !== 16'h2800 || bus.active !== 4'b0001) begin
      bad++; $display("[TB] FAIL early_rel_entry: amp=%h active=%b want 2800 0001", ampOf(0), bus.active);
    end
    applyTicks(19);
    total++;
    if (ampOf(0) !== 16'h0200) begin
      bad++; $display("[TB] FAIL early_rel19: got %h want 0200", ampOf(0));
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'h0000 || bus.active !== 4'b0000) begin
      bad++; $display("[TB] FAIL early_off: amp=%h active=%b want 0000 0000", ampOf(0), bus.active);
    end
  endtask

  task automatic test_retrigger();
    bus.gate = 4'b0110;
    applyTicks(192);
    total++;
    if (bus.amplitude !== 64'h0000_8000_8000_0000 || bus.active !== 4'b0110) begin
      bad++; $display("[TB] FAIL retrig_setup: amp=%h active=%b want 0000800080000000 0110",
                      bus.amplitude, bus.active);
    end
    bus.gate = 4'b0100;
    applyTick();
    bus.gate = 4'b0110;
    applyTick();
    total++;
    if (bus.amplitude !== 64'h0000_8000_8400_0000 || bus.active !== 4'b0110) begin
      bad++; $display("[TB] FAIL retrig_attack: amp=%h active=%b want 0000800084000000 0110",
                      bus.amplitude, bus.active);
    end
    applyTick();
    total++;
    if (bus.amplitude !== 64'h0000_8000_8800_0000) begin
      bad++; $display("[TB] FAIL retrig_climb: amp=%h want 0000800088000000", bus.amplitude);
    end
    bus.gate = 4'b0000;
    applyTicks(80);
    total++;
    if (bus.amplitude !== 64'h0 || bus.active !== 4'b0000) begin
      bad++; $display("[TB] FAIL retrig_cleanup: amp=%h active=%b want 0 0000", bus.amplitude, bus.active);
    end
  endtask

  task automatic test_zero_rates();
    setRates(16'h0, 16'h0, 16'h8000, 16'h0);
    bus.gate = 4'b0001;
    applyTick();
    total++;
    if (ampOf(0) !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL zero_attack: got %h want FFFF", ampOf(0));
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'h8000) begin
      bad++; $display("[TB] FAIL zero_decay: got %h want 8000", ampOf(0));
    end
    bus.sus = 16'h4000;
    applyTick();
    total++;
    if (ampOf(0) !== 16'h4000) begin
      bad++; $display("[TB] FAIL live_sustain: got %h want 4000", ampOf(0));
    end
    bus.gate = 4'b0000;
    applyTick();
    total++;
    if (ampOf(0) !== 16'h4000 || bus.active !== 4'b0001) begin
      bad++; $display("[TB] FAIL zero_rel_entry: amp=%h active=%b want 4000 0001", ampOf(0), bus.active);
    end
    applyTick();
    total++;
    if (ampOf(0) !== 16'h0000 || bus.active !== 4'b0000) begin
      bad++; $display("[TB] FAIL zero_release: amp=%h active=%b want 0000 0000", ampOf(0), bus.active);
    end
  endtask

  task automatic test_reset_midpass();
    setRates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
    bus.gate = 4'b0011;
    applyTicks(2);
    total++;
    if (bus.amplitude !== 64'h0000_0000_0800_0800) begin
      bad++; $display("[TB] FAIL midpass_setup: amp=%h want 0000000008000800", bus.amplitude);
    end
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.amplitude !== 64'h0 || bus.active !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("[TB] FAIL midpass_reset: amp=%h active=%b busy=%b done=%b want 0 0000 0 0",
                      bus.amplitude, bus.active, bus.busy, bus.done);
    end
    applyTick();
    total++;
    if (bus.amplitude !== 64'h0000_0000_0400_0400 || bus.active !== 4'b0011) begin
      bad++; $display("[TB] FAIL midpass_restart: amp=%h active=%b want 0000000004000400 0011",
                      bus.amplitude, bus.active);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.sample_tick = 1'b0;
    bus.gate = 4'b0000;
    setRates(16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    test_reset();
    test_timing();
    test_envelope();
    test_early_release();
    test_retrigger();
    test_zero_rates();
    test_reset_midpass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
